// File: rtl/systolic_op_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_op_sequencer
//
// Turns one 32-bit control instruction into cycle-by-cycle strobes for the
// systolic datapath. The phases run in this fixed order: CLEAR, LOAD_L,
// LOAD_T, SWAP, SHIFT and then DONE. A phase whose instruction bits are all
// clear is skipped and takes no cycles.
//
// Handshake: the instruction transfers on a cycle where instr_valid and
// instr_ready are both high. instr_ready is high only in IDLE. The word is
// latched at the transfer, so later changes on instr are ignored until the
// sequencer returns to IDLE. done pulses for one cycle when the sequence
// completes. A cycle with abort high in any non-IDLE state returns the
// sequencer to IDLE without a done pulse.
//
// Ports:
//   clk, fsm_rst_n          clock, asynchronous active-low reset
//   instr_valid/instr_ready instruction handshake
//   instr                   instruction word
//   abort                   synchronous cancel of the current instruction
//   busy, done, state_out   status: busy, completion pulse, state encoding
//   dp_rd_en, dp_rd_addr    data-memory row read
//   left_wr_en, top_wr_en,  buffer row writes and the row index
//   buf_wr_row
//   swap_left, swap_top     buffer swap pulses
//   shift_right, shift_down array shift enables
//   acc_en                  accumulate enable
//   clr_acc, clr_array,     clear pulses
//   clr_left, clr_top
// -----------------------------------------------------------------------------
module systolic_op_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int MATRIX_SIZE   = 8,
    parameter int DP_ADDR_WIDTH = 10,
    parameter int INSTR_WIDTH   = 32,
    parameter int SHIFT_LEN     = 3*MATRIX_SIZE-2
) (
    input  logic                           clk,
    input  logic                           fsm_rst_n,
    input  logic                           instr_valid,
    output logic                           instr_ready,
    input  logic [INSTR_WIDTH-1:0]         instr,
    input  logic                           abort,
    output logic                           busy,
    output logic                           done,
    output logic [2:0]                     state_out,
    output logic                           dp_rd_en,
    output logic [DP_ADDR_WIDTH-1:0]       dp_rd_addr,
    output logic                           left_wr_en,
    output logic                           top_wr_en,
    output logic [$clog2(MATRIX_SIZE)-1:0] buf_wr_row,
    output logic                           swap_left,
    output logic                           swap_top,
    output logic                           shift_right,
    output logic                           shift_down,
    output logic                           acc_en,
    output logic                           clr_acc,
    output logic                           clr_array,
    output logic                           clr_left,
    output logic                           clr_top
);

    localparam int ROW_W = $clog2(MATRIX_SIZE);
    // The counter must be able to hold N for the load phases and
    // SHIFT_LEN-1 for the shift phase.
    localparam int CNT_W = $clog2(SHIFT_LEN + MATRIX_SIZE + 2);
    localparam logic [31:0] L_DW = 32'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LOAD_L = 3'd2,
        S_LOAD_T = 3'd3,
        S_SWAP   = 3'd4,
        S_SHIFT  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
    logic [INSTR_WIDTH-1:0]   r_instr;
    logic [DP_ADDR_WIDTH-1:0] w_base;
    logic                     w_unused;

    // Returns the first requested phase whose encoding is >= from. The
    // phase encodings increase in execution order, which makes this
    // comparison valid. The checks run from the last phase to the first,
    // so the earliest requested phase takes priority.
    function automatic state_t first_phase(input logic [INSTR_WIDTH-1:0] w,
                                           input logic [2:0] from);
        state_t s;
        s = S_DONE;
        if (from <= 3'd5 && (w[27] | w[26])) s = S_SHIFT;
        if (from <= 3'd4 && (w[29] | w[28])) s = S_SWAP;
        if (from <= 3'd3 && w[30])           s = S_LOAD_T;
        if (from <= 3'd2 && w[31])           s = S_LOAD_L;
        if (from <= 3'd1 && (|w[17:14]))     s = S_CLEAR;
        return s;
    endfunction

    // When the instruction also loads the left buffer, the top buffer
    // rows start directly after the left rows in memory.
    assign w_base = r_instr[DP_ADDR_WIDTH-1:0] +
                    ((r_state == S_LOAD_T && r_instr[31]) ?
                     DP_ADDR_WIDTH'(MATRIX_SIZE) : '0);

    // These instruction bits are ignored. The NOP bit needs no logic
    // because any word without phase bits goes straight to DONE.
    assign w_unused = ^{r_instr[25:18], r_instr[13:DP_ADDR_WIDTH], L_DW[0]};

    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_instr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_IDLE && instr_valid)
                r_instr <= instr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        instr_ready = 1'b0;
        done        = 1'b0;
        dp_rd_en    = 1'b0;
        dp_rd_addr  = '0;
        left_wr_en  = 1'b0;
        top_wr_en   = 1'b0;
        buf_wr_row  = '0;
        swap_left   = 1'b0;
        swap_top    = 1'b0;
        shift_right = 1'b0;
        shift_down  = 1'b0;
        acc_en      = 1'b0;
        clr_acc     = 1'b0;
        clr_array   = 1'b0;
        clr_left    = 1'b0;
        clr_top     = 1'b0;

        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_state_nxt = first_phase(instr, 3'd1);
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                clr_acc     = r_instr[17];
                clr_array   = r_instr[16];
                clr_left    = r_instr[15];
                clr_top     = r_instr[14];
                w_state_nxt = first_phase(r_instr, 3'd2);
                w_cnt_nxt   = '0;
            end
            S_LOAD_L, S_LOAD_T: begin
                // Memory reads happen for k = 0..N-1. Each buffer write comes
                // one cycle after its read, to cover the read latency.
                if (r_cnt < CNT_W'(MATRIX_SIZE)) begin
                    dp_rd_en   = 1'b1;
                    dp_rd_addr = w_base + DP_ADDR_WIDTH'(r_cnt);
                end
                if (r_cnt != '0) begin
                    left_wr_en = (r_state == S_LOAD_L);
                    top_wr_en  = (r_state == S_LOAD_T);
                    buf_wr_row = ROW_W'(r_cnt - CNT_W'(1));
                end
                if (r_cnt == CNT_W'(MATRIX_SIZE)) begin
                    w_state_nxt = first_phase(r_instr,
                                  (r_state == S_LOAD_L) ? 3'd3 : 3'd4);
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SWAP: begin
                swap_left   = r_instr[29];
                swap_top    = r_instr[28];
                w_state_nxt = first_phase(r_instr, 3'd5);
                w_cnt_nxt   = '0;
            end
            S_SHIFT: begin
                shift_right = r_instr[27];
                shift_down  = r_instr[26];
                acc_en      = 1'b1;
                if (r_cnt == CNT_W'(SHIFT_LEN - 1)) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign state_out = r_state;

endmodule

// File: tb/tb_systolic_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_systolic_op_sequencer
//
// Applies directed instructions to systolic_op_sequencer. For each
// instruction the expected strobe events are pushed into exp_q before the
// instruction is driven. Each event is tagged with its cycle offset from the
// accept cycle, which is offset 0. A monitor samples the outputs on every
// falling clock edge. On any cycle where a strobe is active, it pops the next
// expected event and compares it. A cycle with strobe activity and nothing
// queued counts as a failure.
// -----------------------------------------------------------------------------
module tb_systolic_op_sequencer;

  localparam int N  = 8;
  localparam int AW = 10;
  localparam int SL = 3*N-2;
  localparam int W  = 40;

  logic          clk;
  logic          fsm_rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic          abort;
  logic          busy;
  logic          done;
  logic [2:0]    state_out;
  logic          dp_rd_en;
  logic [AW-1:0] dp_rd_addr;
  logic          left_wr_en;
  logic          top_wr_en;
  logic [2:0]    buf_wr_row;
  logic          swap_left;
  logic          swap_top;
  logic          shift_right;
  logic          shift_down;
  logic          acc_en;
  logic          clr_acc;
  logic          clr_array;
  logic          clr_left;
  logic          clr_top;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];

  systolic_op_sequencer #(
    .DATA_WIDTH(8), .MATRIX_SIZE(N), .DP_ADDR_WIDTH(AW), .INSTR_WIDTH(32)
  ) dut (
    .clk(clk), .fsm_rst_n(fsm_rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .abort(abort), .busy(busy), .done(done), .state_out(state_out),
    .dp_rd_en(dp_rd_en), .dp_rd_addr(dp_rd_addr),
    .left_wr_en(left_wr_en), .top_wr_en(top_wr_en), .buf_wr_row(buf_wr_row),
    .swap_left(swap_left), .swap_top(swap_top),
    .shift_right(shift_right), .shift_down(shift_down), .acc_en(acc_en),
    .clr_acc(clr_acc), .clr_array(clr_array),
    .clr_left(clr_left), .clr_top(clr_top)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- expected-event helpers ----------------
  // Event word: {pad, offset, done, rd_en, rd_addr, left_wr, top_wr, row,
  //              {swap_left,swap_top}, {shift_right,shift_down}, acc,
  //              {clr_acc,clr_array,clr_left,clr_top}}
  function automatic logic [W-1:0] mk(input int off, input logic dn, input logic rd,
                                      input logic [AW-1:0] a, input logic lw,
                                      input logic tw, input logic [2:0] row,
                                      input logic [1:0] sw, input logic [1:0] sh,
                                      input logic acc, input logic [3:0] clr);
    return {6'd0, 8'(off), dn, rd, a, lw, tw, row, sw, sh, acc, clr};
  endfunction

  // Load phase from counter k=0 to last_k (N for a complete phase).
  task automatic push_load(input logic top, input logic [AW-1:0] base,
                           input int start, input int last_k);
    for (int k = 0; k <= last_k; k++) begin
      logic rd, wr;
      logic [AW-1:0] a;
      logic [2:0] row;
      rd  = (k < N);
      a   = rd ? AW'(base + AW'(k)) : '0;
      wr  = (k >= 1);
      row = wr ? 3'(k-1) : 3'd0;
      exp_q.push_back(mk(start+k, 1'b0, rd, a, !top && wr, top && wr, row,
                         2'b00, 2'b00, 1'b0, 4'b0000));
    end
  endtask

  task automatic push_shift(input logic [1:0] sh, input int start, input int count);
    for (int k = 0; k < count; k++)
      exp_q.push_back(mk(start+k, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0,
                         2'b00, sh, 1'b1, 4'b0000));
  endtask

  task automatic push_done(input int off);
    exp_q.push_back(mk(off, 1'b1, 1'b0, '0, 1'b0, 1'b0, 3'd0,
                       2'b00, 2'b00, 1'b0, 4'b0000));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, e;
    logic active;
    if (instr_valid && instr_ready) cyc = 0;
    else cyc = cyc + 1;
    active = done | dp_rd_en | (|dp_rd_addr) | left_wr_en | top_wr_en |
             (|buf_wr_row) | swap_left | swap_top | shift_right |
             shift_down | acc_en | clr_acc | clr_array | clr_left | clr_top;
    if (active) begin
      got = {6'd0, 8'(cyc), done, dp_rd_en, dp_rd_addr, left_wr_en, top_wr_en,
             buf_wr_row, swap_left, swap_top, shift_right, shift_down, acc_en,
             clr_acc, clr_array, clr_left, clr_top};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got %h, required no activity", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL strobe_event: got %h, required %h", got, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Call this #1 after a rising edge. It returns #1 after the accepting edge,
  // which is in cycle 1 of the instruction.
  task automatic send(input logic [31:0] w);
    logic ok;
    ok = 1'b0;
    instr = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = $urandom;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout: instr_ready never high, required 1");
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk({nm, "_busy_clear"}, 32'(busy), 32'd0);
    chk({nm, "_ready_after"}, 32'(instr_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    fsm_rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_busy",  32'(busy), 32'd0);
    chk("reset_state", 32'(state_out), 32'd0);
    chk("reset_done",  32'(done), 32'd0);
    chk("reset_rd_en", 32'(dp_rd_en), 32'd0);
    fsm_rst_n = 1'b1;
    @(posedge clk); #1;

    // Load left from address 1: reads in cycles 1..8, writes in 2..9, done in 10.
    push_load(1'b0, 10'd1, 1, N);
    push_done(10);
    send(32'h8000_0001);
    wait_idle("load_left");

    // Load both buffers from address 3: left uses 3..10, top uses 11..18.
    push_load(1'b0, 10'd3, 1, N);
    push_load(1'b1, 10'd11, 10, N);
    push_done(19);
    send(32'hC000_0003);
    wait_idle("load_both");

    // Load top only from address 5.
    push_load(1'b1, 10'd5, 1, N);
    push_done(10);
    send(32'h4000_0005);
    wait_idle("load_top");

    // Both swaps in cycle 1, done in cycle 2.
    exp_q.push_back(mk(1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, 2'b11, 2'b00, 1'b0, 4'b0000));
    push_done(2);
    send(32'h3000_0003);
    wait_idle("swap");

    // Shift right with accumulate in cycles 1..22, done in cycle 23.
    push_shift(2'b10, 1, SL);
    push_done(SL + 1);
    send(32'h0800_2F30);
    wait_idle("shift_right");

    // All four clears in cycle 1, done in cycle 2.
    exp_q.push_back(mk(1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00, 1'b0, 4'b1111));
    push_done(2);
    send(32'h0003_C001);
    wait_idle("clears");

    // NOP: done in cycle 1 with no strobes.
    push_done(1);
    send(32'h0010_0000);
    wait_idle("nop");

    // Phase order: clear acc/array in cycle 1, swap left in cycle 2,
    // shift down in cycles 3..24, done in cycle 25.
    exp_q.push_back(mk(1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00, 1'b0, 4'b1100));
    exp_q.push_back(mk(2, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, 2'b10, 2'b00, 1'b0, 4'b0000));
    push_shift(2'b01, 3, SL);
    push_done(SL + 3);
    send(32'h2403_0010);
    wait_idle("combo");

    // Address wrap: 0x3FC..0x3FF, then 0x000..0x003.
    push_load(1'b0, 10'h3FC, 1, N);
    push_done(10);
    send(32'h8000_03FC);
    wait_idle("wrap");

    // abort held high in IDLE while an instruction is offered: it is still accepted.
    push_done(1);
    abort = 1'b1;
    send(32'h0010_0000);
    abort = 1'b0;
    wait_idle("abort_idle");

    // Abort in LOAD_L at k=4 (cycle 5): IDLE in cycle 6, no done.
    push_load(1'b0, 10'h040, 1, 4);
    send(32'h8000_0040);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_state", 32'(state_out), 32'd2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_state", 32'(state_out), 32'd0);
    chk("abort_done",  32'(done), 32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset during SHIFT in cycle 5.
    push_shift(2'b01, 1, 5);
    send(32'h0400_0000);
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_pre_state", 32'(state_out), 32'd5);
    fsm_rst_n = 1'b0;
    #1;
    chk("rst_shift_down", 32'(shift_down), 32'd0);
    chk("rst_acc_en",     32'(acc_en), 32'd0);
    chk("rst_state",      32'(state_out), 32'd0);
    @(posedge clk); #1;
    fsm_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready_after", 32'(instr_ready), 32'd1);

    // The latched instruction was discarded: a NOP completes normally.
    push_done(1);
    send(32'h0010_0000);
    wait_idle("post_reset");

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_op_sequencer.md
Name: systolic_op_sequencer

Overview:
- Expands one fetched 32-bit control instruction into cycle-by-cycle strobes for the systolic datapath: clears, row-wise buffer loads from data memory, buffer swaps, and shift/accumulate runs.
- Sits between tiny_fsm_control (instruction source) and the left/top buffers, systolic array and accumulators.
- Takes one instruction at a time over a valid/ready handshake and pulses done when the instruction has completed.

Parameters:
- DATA_WIDTH, 8, element width; carried for datapath consistency, no internal use.
- MATRIX_SIZE, 8, array dimension N; rows per buffer load.
- DP_ADDR_WIDTH, 10, data-memory row address width.
- INSTR_WIDTH, 32, instruction width.
- SHIFT_LEN, 3*MATRIX_SIZE-2, cycles per shift/accumulate run.

Ports:
- clk  in  1  clock
- fsm_rst_n  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- instr  in  INSTR_WIDTH  instruction word
- abort  in  1  synchronous cancel of current instruction
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- state_out  out  3  current state encoding
- dp_rd_en  out  1  data-memory read enable
- dp_rd_addr  out  DP_ADDR_WIDTH  data-memory row address
- left_wr_en  out  1  left buffer row write
- top_wr_en  out  1  top buffer row write
- buf_wr_row  out  $clog2(MATRIX_SIZE)  buffer row index
- swap_left, swap_top  out  1 each  buffer swap pulses
- shift_right, shift_down  out  1 each  array shift enables
- acc_en  out  1  accumulate enable
- clr_acc, clr_array, clr_left, clr_top  out  1 each  clear pulses

Behaviour:
- Instruction fields:
  - bit31 LOAD_LEFT, bit30 LOAD_TOP, bit29 SWAP_LEFT, bit28 SWAP_TOP.
  - bit27 SHIFT_RIGHT, bit26 SHIFT_DOWN, bit20 NOP.
  - bit17 CLR_ACC, bit16 CLR_ARRAY, bit15 CLR_LEFT, bit14 CLR_TOP.
  - ADDR = instr[DP_ADDR_WIDTH-1:0]; all other bits ignored.
- States and encoding: IDLE=0, CLEAR=1, LOAD_L=2, LOAD_T=3, SWAP=4, SHIFT=5, DONE=6.
- Reset values: state IDLE, instr_ready=1, all other outputs 0, counters 0.
- Accept:
  - instr_ready=1 only in IDLE.
  - Transfer occurs on instr_valid & instr_ready; instr is latched.
  - The next state is the first phase whose bits are set, in order CLEAR, LOAD_L, LOAD_T, SWAP, SHIFT. Phases with no bits set take zero cycles.
  - If no phase bits are set (NOP or all-zero word), go directly to DONE.
  - The NOP bit is ignored when other phase bits are set.
- CLEAR: 1 cycle; each requested clr_* is high for that cycle only.
- LOAD_L: N+1 cycles, counter k=0..N.
  - k<N: dp_rd_en=1, dp_rd_addr=ADDR+k.
  - k>=1: left_wr_en=1, buf_wr_row=k-1. This accounts for the 1-cycle memory read latency.
- LOAD_T: same timing as LOAD_L using top_wr_en. Base address is ADDR+N if LOAD_LEFT is also set, else ADDR.
- Address arithmetic is modulo 2^DP_ADDR_WIDTH (wraps silently).
- SWAP: 1 cycle; swap_left and swap_top follow their bits and are simultaneous when both are set.
- SHIFT: SHIFT_LEN cycles.
  - shift_right and shift_down follow their bits and stay steady for the whole phase.
  - acc_en=1 throughout the phase.
- DONE: 1 cycle, done=1, then IDLE. Back-to-back acceptance is possible the cycle after DONE.
- Outputs are registered-state decodes; none is high outside its phase.
- abort, in any non-IDLE state:
  - Next cycle is IDLE with all strobes 0 and no done pulse.
  - abort in IDLE has no effect. abort together with a valid transfer in IDLE still accepts.
- Async reset mid-instruction clears everything immediately; the latched instruction is discarded.
- instr changing while busy is ignored.

Test Plan:
- Load left: reset, accept 0x8000_0001 at cycle 0 -> dp_rd_addr 1..8 in cycles 1..8; left_wr_en rows 0..7 in cycles 2..9; done in cycle 10; instr_ready in cycle 11.
- Load both: 0xC000_0003 -> left uses addresses 3..10, top uses 11..18; no overlap of left_wr_en and top_wr_en; done in cycle 19.
- Swap and shift: 0x3000_0003 -> swap_left & swap_top high in cycle 1 only, done in cycle 2. 0x0800_2F30 -> shift_right & acc_en high for cycles 1..22, shift_down=0, done in cycle 23.
- Clears and NOP: 0x0003_C001 -> all four clr_* high in cycle 1, done in cycle 2. 0x0010_0000 -> done in cycle 1 with no strobes.
- Address wrap: 0x8000_03FC -> dp_rd_addr 0x3FC..0x3FF, then 0x000..0x003.
- Abort and reset: abort in LOAD_L at k=4 -> next cycle IDLE, strobes 0, no done. fsm_rst_n low mid-SHIFT -> outputs 0 asynchronously, instr_ready=1 after release.
